// File: rtl/warp_dispatcher.sv
// warp_dispatcher
//   Scatter/gather engine between the 32-bit-style stream FIFOs and an array
//   of kernel instances. One batch is: read WORDS bus words, spread their lanes
//   over THREAD_NUMBER kernel inputs, wait for every kernel to complete, then
//   pack the results back into WORDS bus words for the output FIFO.
//
//   Handshakes: in_rd_en is a read strobe; the FIFO answers with in_valid one
//   cycle later. out_wr_en is asserted only when out_full is low, and a word
//   counts as transferred on every cycle out_wr_en is high. kern_in_valid is a
//   level held from load until the block returns to IDLE; the first
//   kern_out_valid[t] seen in EXEC is the result for thread t.
//
//   Ports:
//     bus_clk, rst (async, active high)
//     quiesce, w_open, r_open    : any of quiesce / !w_open / !r_open aborts to IDLE
//     in_rd_en, in_empty, in_data, in_valid   : input FIFO side
//     out_wr_en, out_data, out_full           : output FIFO side
//     kern_in_data/valid, kern_out_data/valid : kernel array, thread t at lane t
//     busy, batch_done, batch_count, exec_error : status
//
//   Optional macro DISPATCH_TIMEOUT_EN: enables an EXEC watchdog of EXEC_TIMEOUT
//   cycles. On expiry exec_error latches and unfinished threads report all-ones.
module warp_dispatcher #(
   parameter int BUS_WIDTH     = 32,
   parameter int LANE_WIDTH    = 16,
   parameter int THREAD_NUMBER = 256,
   parameter int EXEC_TIMEOUT  = 4096
) (
   input  logic                                bus_clk,
   input  logic                                rst,
   input  logic                                quiesce,
   input  logic                                w_open,
   input  logic                                r_open,
   output logic                                in_rd_en,
   input  logic                                in_empty,
   input  logic [BUS_WIDTH-1:0]                in_data,
   input  logic                                in_valid,
   output logic                                out_wr_en,
   output logic [BUS_WIDTH-1:0]                out_data,
   input  logic                                out_full,
   output logic [THREAD_NUMBER*LANE_WIDTH-1:0] kern_in_data,
   output logic [THREAD_NUMBER-1:0]            kern_in_valid,
   input  logic [THREAD_NUMBER*LANE_WIDTH-1:0] kern_out_data,
   input  logic [THREAD_NUMBER-1:0]            kern_out_valid,
   output logic                                busy,
   output logic                                batch_done,
   output logic [15:0]                         batch_count,
   output logic                                exec_error
);

   localparam int L     = BUS_WIDTH / LANE_WIDTH;
   localparam int WORDS = THREAD_NUMBER / L;
   localparam int CW    = $clog2(WORDS) + 1;
   localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
   localparam logic [CW-1:0] WORDS_C   = CW'(WORDS);

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      RECV = 4'b0010,
      EXEC = 4'b0100,
      SEND = 4'b1000
   } state_t;

   state_t                              state, state_next;
   logic [CW-1:0]                       issued, received, send_idx;
   logic [THREAD_NUMBER-1:0]            done;
   logic [THREAD_NUMBER*LANE_WIDTH-1:0] results;
   logic                                abort, last_write, timeout;

   assign abort      = quiesce | ~w_open | ~r_open;
   assign in_rd_en   = (state == RECV) && !abort && !in_empty && (issued < WORDS_C);
   assign out_wr_en  = (state == SEND) && !abort && !out_full;
   assign last_write = out_wr_en && (send_idx == LAST_WORD);
   assign busy       = (state != IDLE);

`ifdef DISPATCH_TIMEOUT_EN
   localparam int TW = $clog2(EXEC_TIMEOUT + 1);
   logic [TW-1:0] exec_cycles;

   // exec_cycles is 0 on the first EXEC cycle, so the EXEC_TIMEOUT-th cycle
   // is the last one spent waiting.
   assign timeout = (state == EXEC) && !(&done) && (exec_cycles == TW'(EXEC_TIMEOUT - 1));

   always_ff @(posedge bus_clk or posedge rst) begin
      if (rst) begin
         exec_cycles <= '0;
         exec_error  <= 1'b0;
      end else begin
         if (state == EXEC) exec_cycles <= exec_cycles + 1'b1;
         else               exec_cycles <= '0;
         if (timeout && !abort) exec_error <= 1'b1;
      end
   end
`else
   assign timeout    = 1'b0;
   assign exec_error = 1'b0;
`endif

   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE:    state_next = RECV;  // no abort means both files are open
            RECV:    if (in_valid && received == LAST_WORD) state_next = EXEC;
            EXEC:    if ((&done) || timeout) state_next = SEND;
            SEND:    if (last_write) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      out_data = '0;
      if (state == SEND) begin
         for (int w = 0; w < WORDS; w++) begin
            if (send_idx == CW'(w)) out_data = results[w*BUS_WIDTH +: BUS_WIDTH];
         end
      end
   end

   always_ff @(posedge bus_clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         issued        <= '0;
         received      <= '0;
         send_idx      <= '0;
         done          <= '0;
         results       <= '0;
         kern_in_data  <= '0;
         kern_in_valid <= '0;
         batch_done    <= 1'b0;
         batch_count   <= '0;
      end else begin
         state      <= state_next;
         batch_done <= 1'b0;

         if (state == RECV && !abort) begin
            if (in_rd_en) issued <= issued + 1'b1;
            if (in_valid) begin
               received <= received + 1'b1;
               // Word k carries threads k*L .. k*L+L-1, which is exactly the
               // k-th bus-wide slice of the flat kernel input vector.
               for (int w = 0; w < WORDS; w++) begin
                  if (received == CW'(w)) begin
                     kern_in_data[w*BUS_WIDTH +: BUS_WIDTH] <= in_data;
                     kern_in_valid[w*L +: L]                <= '1;
                  end
               end
            end
         end

         if (state == EXEC && !abort) begin
            for (int t = 0; t < THREAD_NUMBER; t++) begin
               if (!done[t] && kern_out_valid[t]) begin
                  results[t*LANE_WIDTH +: LANE_WIDTH] <= kern_out_data[t*LANE_WIDTH +: LANE_WIDTH];
                  done[t]                             <= 1'b1;
               end else if (!done[t] && timeout) begin
                  results[t*LANE_WIDTH +: LANE_WIDTH] <= '1;
               end
            end
         end

         if (out_wr_en) begin
            send_idx <= send_idx + 1'b1;
            if (last_write) begin
               batch_done  <= 1'b1;
               batch_count <= batch_count + 16'd1;
            end
         end

         // Last so it overrides the updates above whenever IDLE is next.
         if (state_next == IDLE) begin
            issued        <= '0;
            received      <= '0;
            send_idx      <= '0;
            done          <= '0;
            kern_in_valid <= '0;
         end
      end
   end

endmodule

// File: doc/warp_dispatcher.md
Name: warp_dispatcher

Overview:
- Parametrised scatter/gather engine between the Xillybus 32-bit stream FIFOs and an array of kernel instances.
- Per batch: reads THREAD_NUMBER lanes from the host-to-FPGA FIFO, unpacks them to kernel inputs, waits until every kernel reports completion, packs results back to the FPGA-to-host FIFO.
- Generalises bus/lane width and thread count, completes on all threads, honours backpressure on send, and counts batches.

Parameters:
BUS_WIDTH, 32, FIFO word width; must be an integer multiple of LANE_WIDTH
LANE_WIDTH, 16, per-thread data width
THREAD_NUMBER, 256, kernel count; must be a multiple of L = BUS_WIDTH/LANE_WIDTH
EXEC_TIMEOUT, 4096, watchdog cycle limit (used only with the optional feature)

Ports:
bus_clk  in  1  single clock for the whole block
rst  in  1  asynchronous, active-high reset
quiesce  in  1  Xillybus core not loaded; aborts to IDLE
w_open  in  1  host write file open
r_open  in  1  host read file open
in_rd_en  out  1  read strobe to input FIFO
in_empty  in  1  input FIFO empty
in_data  in  BUS_WIDTH  input FIFO data, valid one cycle after in_rd_en
in_valid  in  1  in_data valid
out_wr_en  out  1  write strobe to output FIFO
out_data  out  BUS_WIDTH  packed result word
out_full  in  1  output FIFO full
kern_in_data  out  THREAD_NUMBER*LANE_WIDTH  thread t at [t*LANE_WIDTH +: LANE_WIDTH]
kern_in_valid  out  THREAD_NUMBER  per-thread input valid (level)
kern_out_data  in  THREAD_NUMBER*LANE_WIDTH  kernel results, same packing
kern_out_valid  in  THREAD_NUMBER  per-thread result valid
busy  out  1  state != IDLE
batch_done  out  1  one-cycle pulse when the last result word is written
batch_count  out  16  completed batches, wraps at 16'hFFFF -> 0
exec_error  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters, done bits and result registers cleared.
- WORDS = THREAD_NUMBER/L.
- States: IDLE, RECV, EXEC, SEND (one-hot).
- Abort: quiesce, ~w_open or ~r_open in any state -> IDLE next cycle. Clears kern_in_valid, counters and done bits. batch_count and exec_error are kept.
- IDLE -> RECV when w_open && r_open (1 cycle).
- RECV:
  - in_rd_en = !in_empty && issued < WORDS; issued increments on in_rd_en.
  - On in_valid, word k = received count: lane j = in_data[j*LANE_WIDTH +: LANE_WIDTH] goes to thread k*L+j, and that thread's kern_in_valid is set.
  - -> EXEC on the cycle received reaches WORDS.
  - Never over-reads the FIFO.
- kern_in_valid stays at level 1 from load until the next IDLE.
- EXEC:
  - For each t, the first kern_out_valid[t]=1 captures kern_out_data lane t into the result register and sets done[t].
  - Later pulses on the same thread are ignored.
  - -> SEND when &done (all threads, any completion order).
- SEND:
  - out_data = results of threads w*L .. w*L+L-1, packed like input; w = send index.
  - out_wr_en = !out_full. w advances only when out_wr_en=1, so no words are dropped while full.
  - After word WORDS-1 is written: batch_done pulses, batch_count++, -> IDLE.
- Simultaneous abort and last send write: abort wins, no batch_done, no count.
- Out-of-range index arithmetic: counters are sized clog2(WORDS)+1 bits, so no wrap occurs within a batch.

Optional Feature:
- DISPATCH_TIMEOUT_EN, defined:
  - EXEC counts cycles from entry.
  - At EXEC_TIMEOUT with done incomplete: exec_error set (sticky until rst), -> SEND.
  - Unfinished threads send all-ones lanes.
- DISPATCH_TIMEOUT_EN undefined:
  - EXEC waits indefinitely.
  - exec_error tied 0; no counter logic.

Test Plan:
1. Defaults, identity kernels (out = in, 3-cycle latency), 128 words 0x00010000+2k -> 128 output words identical; batch_done pulse; batch_count=1.
2. Kernels finishing in reverse thread order (thread 255 first) -> SEND entered only after thread 0 completes; output still in thread order.
3. out_full toggled 1 every other cycle during SEND -> exactly 128 writes, no word skipped or duplicated.
4. w_open dropped mid-RECV after 40 words -> IDLE next cycle; kern_in_valid all 0; reopen with a fresh batch -> correct results; batch_count increments once.
5. BUS_WIDTH=64, LANE_WIDTH=8, THREAD_NUMBER=32 (L=8, 4 words) -> byte lanes map thread k*8+j; round trip correct.
6. With DISPATCH_TIMEOUT_EN and EXEC_TIMEOUT=100, thread 7 never valid -> SEND at cycle 100; lane 7 = 0xFFFF; exec_error=1.
